// File: rtl/cnt_arbiter.sv
// Round-robin arbiter/sequencer sharing one counter datapath between N requesters.
// One job in flight at a time: arbitrate, issue, wait for the result, return it with a tag.
module cnt_arbiter #(
    parameter int N       = 4,
    parameter int W       = 11,
    parameter int TAG_W   = $clog2(N),
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_rdy,
    output logic [N-1:0]     req_ack,
    input  logic [N*W-1:0]   req_int,
    output logic [N-1:0]     rsp_rdy,
    input  logic [N-1:0]     rsp_ack,
    output logic [W-1:0]     rsp_int,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             d_irdy,
    input  logic             d_iack,
    output logic [W-1:0]     d_iint,
    input  logic             d_ordy,
    output logic             d_oack,
    input  logic [W-1:0]     d_oint,
    output logic             busy,
    output logic             err,
    output logic [TAG_W-1:0] err_tag,
    output logic [15:0]      job_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RETURN = 2'd3;

    logic [1:0]       state;
    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] next_grant;
    logic [TAG_W-1:0] tag_q;
    logic [W-1:0]     result;
    logic [15:0]      wait_cnt;

    // Scan from the farthest candidate to the nearest so the one closest after ptr wins.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        next_grant = ptr;
        for (int k = N; k >= 1; k--) begin
            if (req_rdy[(int'(ptr) + k) % N]) begin
                next_grant = TAG_W'((int'(ptr) + k) % N);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= TAG_W'(N - 1);
            grant    <= '0;
            tag_q    <= '0;
            result   <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
            err_tag  <= '0;
            job_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_rdy) begin
                        grant <= next_grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!req_rdy[grant]) begin
                        state <= IDLE;
                    end else if (d_iack) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (d_ordy) begin
                        result <= d_oint;
                        tag_q  <= grant;
                        state  <= RETURN;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        // Abandoned job: its owner gets lowest priority, as after a normal completion.
                        err     <= 1'b1;
                        err_tag <= grant;
                        ptr     <= grant;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RETURN: begin
                    if (rsp_ack[grant]) begin
                        ptr     <= grant;
                        job_cnt <= job_cnt + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack = '0;
        rsp_rdy = '0;
        d_irdy  = 1'b0;
        d_iint  = '0;
        d_oack  = 1'b0;
        case (state)
            ISSUE: begin
                d_irdy         = req_rdy[grant];
                d_iint         = req_int[int'(grant)*W +: W];
                req_ack[grant] = d_iack;
            end
            WAIT:    d_oack = 1'b1;
            RETURN:  rsp_rdy[grant] = 1'b1;
            default: ;
        endcase
    end

    // result and tag_q only load on entry to RETURN, so they hold their values elsewhere.
    assign rsp_int = result;
    assign rsp_tag = tag_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cnt_arbiter.sv
// Randomized self-checking bench for cnt_arbiter: the bench plays requesters and an
// incrementing datapath, and predicts grants/results/counters with a job-level model.
module tb_cnt_arbiter;

    localparam int N     = 4;
    localparam int W     = 11;
    localparam int TAG_W = 2;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_rdy;
    logic [N-1:0]     req_ack;
    logic [N*W-1:0]   req_int;
    logic [N-1:0]     rsp_rdy;
    logic [N-1:0]     rsp_ack;
    logic [W-1:0]     rsp_int;
    logic [TAG_W-1:0] rsp_tag;
    logic             d_irdy, d_iack, d_ordy, d_oack;
    logic [W-1:0]     d_iint, d_oint;
    logic             busy, err;
    logic [TAG_W-1:0] err_tag;
    logic [15:0]      job_cnt;

    cnt_arbiter #(.N(N), .W(W), .TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_rdy(req_rdy), .req_ack(req_ack), .req_int(req_int),
        .rsp_rdy(rsp_rdy), .rsp_ack(rsp_ack), .rsp_int(rsp_int), .rsp_tag(rsp_tag),
        .d_irdy(d_irdy), .d_iack(d_iack), .d_iint(d_iint),
        .d_ordy(d_ordy), .d_oack(d_oack), .d_oint(d_oint),
        .busy(busy), .err(err), .err_tag(err_tag), .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Job-level reference model.
    int          m_ptr;
    int          m_cnt;
    logic        m_err;
    int          m_err_tag;
    logic [N-1:0] pend;
    logic [W-1:0] pay [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        req_rdy = pend;
        for (int i = 0; i < N; i++) req_int[i*W +: W] = pay[i];
    endtask

    task automatic raise(input int i, input logic [W-1:0] p);
        pend[i] = 1'b1;
        pay[i]  = p;
    endtask

    // Round-robin rule: first pending requester after the last served one, wrapping.
    function automatic int pick();
        for (int k = 1; k <= N; k++)
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = N - 1; m_cnt = 0; m_err = 1'b0; m_err_tag = 0;
        pend = '0;
        for (int i = 0; i < N; i++) pay[i] = '0;
    endtask

    // One complete job starting in IDLE with at least one request pending.
    task automatic run_job(input bit to, input int iack_dly, input int ord_dly,
                           input int hold, input logic [N-1:0] new_mask);
        int           g, cnt;
        bit           seen;
        logic [W-1:0] p, r;
        logic [N-1:0] oh;
        drive_reqs();
        g  = pick();
        p  = pay[g];
        oh = '0;
        oh[g] = 1'b1;
        cnt = 0;
        do begin step(); cnt++; end while (!d_irdy && cnt < 20);
        check("arb_latency", cnt, 1);
        check("d_iint", d_iint, p);
        check("req_ack_pre", req_ack, 0);
        check("busy_issue", busy, 1);
        repeat (iack_dly) begin
            step();
            check("irdy_hold", {d_irdy, d_iint}, {1'b1, p});
        end
        d_iack = 1'b1;
        #1;
        check("req_ack", req_ack, oh);
        step();
        d_iack  = 1'b0;
        pend[g] = 1'b0;
        drive_reqs();
        check("wait_oack", {d_oack, d_irdy}, 2'b10);
        if (to) begin
            cnt = 0; seen = 0;
            while (busy && cnt < 50) begin
                step(); cnt++;
                if (rsp_rdy != '0) seen = 1;
            end
            m_err = 1'b1; m_err_tag = g; m_ptr = g;
            check("timeout_cycles", cnt, TO);
            check("timeout_no_rsp", seen, 0);
            check("err", err, m_err);
            check("err_tag", err_tag, m_err_tag);
            check("job_cnt_to", job_cnt, m_cnt);
            return;
        end
        repeat (ord_dly) step();
        r      = p + 1'b1;
        d_ordy = 1'b1;
        d_oint = r;
        step();
        d_ordy = 1'b0;
        d_oint = W'($urandom);
        check("rsp_rdy", rsp_rdy, oh);
        check("rsp_int", rsp_int, r);
        check("rsp_tag", rsp_tag, g);
        check("ret_oack", d_oack, 0);
        for (int i = 0; i < N; i++)
            if (new_mask[i] && !pend[i]) raise(i, W'($urandom));
        drive_reqs();
        repeat (hold) begin
            rsp_ack = N'($urandom) & ~oh;
            step();
            check("rsp_hold", {req_ack, rsp_rdy, rsp_int, rsp_tag},
                  {{N{1'b0}}, oh, r, TAG_W'(g)});
        end
        rsp_ack = oh | N'($urandom);
        step();
        rsp_ack = '0;
        m_ptr = g;
        m_cnt = (m_cnt + 1) & 16'hffff;
        check("idle_after", {busy, rsp_rdy}, 0);
        check("job_cnt", job_cnt, m_cnt);
        check("rsp_held", {rsp_int, rsp_tag}, {r, TAG_W'(g)});
        check("err_keep", {err, err_tag}, {m_err, TAG_W'(m_err_tag)});
    endtask

    initial begin
        rst = 1'b0;
        req_rdy = '0; req_int = '0; rsp_ack = '0;
        d_iack = 1'b0; d_ordy = 1'b0; d_oint = '0;
        model_reset();
        #3;
        check("rst_outs", {req_ack, rsp_rdy, d_irdy, d_oack, busy}, 0);
        check("rst_data", {rsp_int, rsp_tag, d_iint}, 0);
        check("rst_status", {err, err_tag, job_cnt}, 0);
        #9 rst = 1'b1;

        // Single requester, payload 5 -> result 6.
        raise(0, 11'd5);
        run_job(0, 0, 0, 0, '0);
        // All four pending: strict rotation, then a fifth job.
        raise(0, 11'd10); raise(1, 11'd20); raise(2, 11'd30); raise(3, 11'd40);
        for (int j = 0; j < 4; j++) run_job(0, j, j, 1, '0);
        raise(2, 11'd2047);
        run_job(0, 1, 1, 0, '0);
        // Park ptr at 1, then 1011 must go 3, 0, 1.
        raise(1, 11'd7);
        run_job(0, 0, 2, 0, '0);
        raise(0, 11'd100); raise(1, 11'd101); raise(3, 11'd103);
        for (int j = 0; j < 3; j++) run_job(0, 0, 0, 0, '0);
        // Timeout on requester 2; result arriving on the last WAIT cycle still wins.
        raise(2, 11'd55);
        run_job(1, 0, 0, 0, '0);
        raise(1, 11'd66);
        run_job(0, 0, TO - 1, 0, '0);
        // Long backpressure with requester 2 waiting.
        raise(0, 11'd77);
        run_job(0, 1, 2, 20, 4'b0100);
        run_job(0, 0, 0, 0, '0);

        for (int j = 0; j < 60; j++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1)
                    raise(i, ($urandom_range(7, 0) == 0) ? 11'h7ff : W'($urandom));
            if (pend == '0) raise(int'($urandom_range(N - 1, 0)), W'($urandom));
            run_job($urandom_range(7, 0) == 0, int'($urandom_range(3, 0)),
                    int'($urandom_range(TO - 1, 0)), int'($urandom_range(4, 0)),
                    N'($urandom));
        end

        // Asynchronous reset in the middle of WAIT.
        pend = '0;
        raise(3, 11'd9);
        drive_reqs();
        step();
        d_iack = 1'b1;
        step();
        d_iack = 1'b0;
        check("pre_rst_wait", {busy, d_oack}, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", {req_ack, rsp_rdy, d_irdy, d_oack, busy}, 0);
        check("async_rst_state", {err, err_tag, job_cnt, rsp_int, rsp_tag}, 0);
        model_reset();
        drive_reqs();
        rst = 1'b1;
        raise(0, 11'd1); raise(1, 11'd2); raise(2, 11'd3); raise(3, 11'd4);
        run_job(0, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
